// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared types and sizing for the fetch sequencer.
//   XLEN            address / instruction width
//   INST_FETCH_NUM  instructions per fetch group (power of 2)
//   IB_ADDR         log2 of fetch-buffer depth; FB_DEPTH is also the initial credit count
//   ib_entry_t      one fetch-buffer lane {pc, inst, valid}
//   fetch_state_t   sequencer state {REQ, WAIT, DRAIN}
package fetch_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int INST_FETCH_NUM = 4;
    localparam int IB_ADDR        = 2;
    localparam int FETCH_NUM      = INST_FETCH_NUM;
    localparam int FB_DEPTH       = 2 ** IB_ADDR;
    localparam int GRP_BYTES      = 4 * FETCH_NUM;
    localparam int GRP_SHIFT      = $clog2(GRP_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ib_entry_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Clear the byte-offset bits inside a fetch group.
    function automatic logic [XLEN-1:0] grp_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:GRP_SHIFT], {GRP_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
//   Bus bundle between the fetch sequencer, the I-cache and the fetch buffer.
//   master : fetch_ctrl side (drives requests and fetch-buffer writes)
//   slave  : I-cache / fetch-buffer side (drives ready, responses and dequeue)
//   Signals: icache_req_valid/addr/ready, icache_resp_valid/data,
//            fb_insts, fb_valid, fb_flush, fb_deq
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                        icache_req_valid;
    logic [XLEN-1:0]             icache_req_addr;
    logic                        icache_req_ready;
    logic                        icache_resp_valid;
    logic [FETCH_NUM*XLEN-1:0]   icache_resp_data;
    ib_entry_t [FETCH_NUM-1:0]   fb_insts;
    logic                        fb_valid;
    logic                        fb_flush;
    logic                        fb_deq;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid, icache_resp_data,
        output fb_insts, fb_valid, fb_flush,
        input  fb_deq
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid, icache_resp_data,
        input  fb_insts, fb_valid, fb_flush,
        output fb_deq
    );

endinterface

// File: rtl/fetch_ctrl_credit_cnt.sv
// fetch_credit_cnt
//   Fetch-buffer credit counter: up/down with load-to-max on flush.
//   clk, reset : clock, synchronous active-low reset (loads MAX)
//   load_i     : reload to MAX (redirect), overrides take/give
//   take_i     : one credit reserved (request handshake)
//   give_i     : one credit returned (fetch-buffer dequeue)
//   zero_o     : no credits left
module fetch_credit_cnt
    import fetch_ctrl_pkg::*;
#(
    parameter int MAX = FB_DEPTH,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic take_i,
    input  logic give_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(MAX);
        end else if (take_i && !give_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - W'(1);
        end else if (give_i && !take_i) begin
            if (cnt_q != W'(MAX)) cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= W'(MAX);
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch sequencer: owns the fetch PC, issues one group-aligned I-cache
//   request at a time, writes returned groups to the fetch buffer and
//   tracks buffer space with credits. Redirect flushes the buffer and
//   drops the stale in-flight response.
//   Ports: clk, reset (sync, active-low), redirect_valid_i, redirect_pc_i,
//          stall_i, bus (fetch_ctrl_if.master), busy_o
//   Optional macro FETCH_CTRL_PERF_EN adds perf_fetch_cnt_o / perf_stall_cnt_o.
//
//   state | meaning
//   REQ   | may issue a request for the current group
//   WAIT  | one live request outstanding
//   DRAIN | one stale request outstanding; its response is discarded
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             stall_i,
    fetch_ctrl_if.master     bus,
    output logic             busy_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
`endif
);

    fetch_state_t              state_q;
    logic [XLEN-1:0]           pc_q;
    logic                      fb_valid_q;
    ib_entry_t [FETCH_NUM-1:0] fb_insts_q;
    ib_entry_t [FETCH_NUM-1:0] grp_d;
    logic [XLEN-1:0]           req_addr;
    logic                      req_valid;
    logic                      req_fire;
    logic                      redirect;
    logic                      cred_zero;

    assign redirect  = reset && redirect_valid_i;
    assign req_addr  = grp_align(pc_q);
    assign req_valid = reset && (state_q == REQ) && !stall_i && !redirect_valid_i && !cred_zero;
    assign req_fire  = req_valid && bus.icache_req_ready;

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = req_addr;
    assign bus.fb_flush         = redirect;
    assign bus.fb_valid         = fb_valid_q;
    assign bus.fb_insts         = fb_insts_q;
    assign busy_o               = (state_q != REQ);

    fetch_credit_cnt #(.MAX(FB_DEPTH)) u_credit (
        .clk    (clk),
        .reset  (reset),
        .load_i (redirect),
        .take_i (req_fire),
        .give_i (bus.fb_deq),
        .zero_o (cred_zero)
    );

    // Lanes below an unaligned PC (redirect target) are marked invalid.
    always_comb begin
        logic [XLEN-1:0] lane_pc;
        grp_d = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
            lane_pc        = req_addr + XLEN'(4 * i);
            grp_d[i].pc    = lane_pc;
            grp_d[i].inst  = bus.icache_resp_data[i*XLEN +: XLEN];
            grp_d[i].valid = (lane_pc >= pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            fb_valid_q <= 1'b0;
            fb_insts_q <= '0;
        end else begin
            fb_valid_q <= 1'b0;
            if (redirect_valid_i) begin
                // req_valid is masked by redirect, so in REQ the request is
                // normally withdrawn; the fire term only matters if that changes.
                pc_q <= redirect_pc_i;
                case (state_q)
                    REQ:     state_q <= req_fire ? DRAIN : REQ;
                    default: state_q <= DRAIN;
                endcase
            end else begin
                case (state_q)
                    REQ: begin
                        if (req_fire) state_q <= WAIT;
                    end
                    WAIT: begin
                        if (bus.icache_resp_valid) begin
                            fb_valid_q <= 1'b1;
                            fb_insts_q <= grp_d;
                            // Advance from the aligned address so an unaligned
                            // redirect target does not skew the following groups.
                            pc_q       <= req_addr + XLEN'(GRP_BYTES);
                            state_q    <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (bus.icache_resp_valid) state_q <= REQ;
                    end
                    default: state_q <= REQ;
                endcase
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (fb_valid_q) perf_fetch_q <= perf_fetch_q + 32'd1;
            if ((state_q == REQ) && (cred_zero || stall_i)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
